// File: rtl/ysyx_22041412_icache_pkg.sv
// Shared constants and state encoding for the IF-stage instruction cache.
package ysyx_22041412_icache_pkg;

  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned BEATS    = 2;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned BEAT_W   = LINE_W / BEATS;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_REFILL   = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  // Drop one refill beat into its slot of the line being assembled.
  function automatic logic [LINE_W-1:0] merge_beat(input logic [LINE_W-1:0] line,
                                                   input logic              beat,
                                                   input logic [BEAT_W-1:0] data);
    logic [LINE_W-1:0] res;
    res = line;
    if (beat) res[LINE_W-1:BEAT_W] = data;
    else      res[BEAT_W-1:0]      = data;
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22041412_icache_array.sv
// Tag and data storage for the instruction cache: one synchronous read port,
// one write port, no reset (valid bits live in the top level).
module ysyx_22041412_icache_array #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 22,
  parameter int unsigned LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  localparam int unsigned NUM_LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [LINE_W-1:0] data_mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/ysyx_22041412_icache.sv
// Direct-mapped instruction cache: returns a 128-bit line per IF request and
// refills misses from memory in two 64-bit beats.
module ysyx_22041412_icache
  import ysyx_22041412_icache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned MEM_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  output logic [LINE_W-1:0] r_data_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [MEM_W-1:0]  mem_rdata_i,
  input  logic              mem_rlast_i
);

  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LADDR_W   = ADDR_W - OFFSET_W;
  localparam int unsigned NUM_LINES = 1 << INDEX_W;

  state_e              state;
  logic [LADDR_W-1:0]  line_q;
  logic [NUM_LINES-1:0] valid_q;
  logic                flush_pend;
  logic                beat_cnt;
  logic                req_dropped;
  logic [LINE_W-1:0]   line_buf;

  logic [INDEX_W-1:0]  idx_q;
  logic [TAG_W-1:0]    tag_q;
  logic                flush_now;
  logic                rd_en;
  logic [TAG_W-1:0]    arr_tag;
  logic [LINE_W-1:0]   arr_data;
  logic [LINE_W-1:0]   line_next;
  logic                refill_done;
  logic                hit;

  assign idx_q       = line_q[INDEX_W-1:0];
  assign tag_q       = line_q[LADDR_W-1:INDEX_W];
  assign flush_now   = flush_pend | flush_i;
  assign rd_en       = (state == S_IDLE) && !flush_now && valid_i;
  assign line_next   = merge_beat(line_buf, beat_cnt, mem_rdata_i);
  assign refill_done = (state == S_REFILL) && mem_rvalid_i && mem_rlast_i;
  assign hit         = valid_q[idx_q] && (arr_tag == tag_q);

  ysyx_22041412_icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (addr_i[OFFSET_W +: INDEX_W]),
    .rd_tag  (arr_tag),
    .rd_data (arr_data),
    .wr_en   (refill_done),
    .wr_idx  (idx_q),
    .wr_tag  (tag_q),
    .wr_data (line_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      line_q      <= '0;
      valid_q     <= '0;
      flush_pend  <= 1'b0;
      beat_cnt    <= 1'b0;
      req_dropped <= 1'b0;
      line_buf    <= '0;
      ready_o     <= 1'b0;
      r_data_o    <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
    end else begin
      ready_o <= 1'b0;
      // A flush seen mid-transaction is deferred to the next IDLE cycle.
      if (flush_i && state != S_IDLE) flush_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (flush_now) begin
            valid_q    <= '0;
            flush_pend <= 1'b0;
          end else if (valid_i) begin
            line_q <= addr_i[ADDR_W-1:OFFSET_W];
            state  <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (!valid_i) begin
            state <= S_IDLE;
          end else if (hit) begin
            r_data_o <= arr_data;
            ready_o  <= 1'b1;
            state    <= S_RESP;
          end else begin
            mem_req_o   <= 1'b1;
            mem_addr_o  <= {line_q, {OFFSET_W{1'b0}}};
            beat_cnt    <= 1'b0;
            req_dropped <= 1'b0;
            state       <= S_MISS_REQ;
          end
        end

        S_MISS_REQ: begin
          if (!valid_i) req_dropped <= 1'b1;
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= S_REFILL;
          end
        end

        S_REFILL: begin
          if (!valid_i) req_dropped <= 1'b1;
          if (mem_rvalid_i) begin
            line_buf <= line_next;
            beat_cnt <= ~beat_cnt;
            if (mem_rlast_i) begin
              // The line is installed even if IF abandoned the request.
              valid_q[idx_q] <= 1'b1;
              if (valid_i && !req_dropped) begin
                r_data_o <= line_next;
                ready_o  <= 1'b1;
                state    <= S_RESP;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end

        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  a_no_beat_before_gnt: assert property (@(posedge clk) disable iff (!rst)
    !((state == S_MISS_REQ) && mem_rvalid_i));

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Self-checking bench for the instruction cache against a line-level reference model.
module tb_ysyx_22041412_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [31:0]  addr_i;
  logic         ready_o;
  logic [127:0] r_data_o;
  logic         flush_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [63:0]  mem_rdata_i;
  logic         mem_rlast_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22041412_icache #(.ADDR_W(32), .INDEX_W(6), .MEM_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .addr_i       (addr_i),
    .ready_o      (ready_o),
    .r_data_o     (r_data_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rlast_i  (mem_rlast_i)
  );

  // Reference model: which line address each direct-mapped slot holds.
  bit          mvalid [64];
  logic [27:0] mline  [64];

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[9:4]] && (mline[a[9:4]] == a[31:4]);
  endfunction

  function automatic void model_install(input logic [31:0] a);
    mvalid[a[9:4]] = 1'b1;
    mline[a[9:4]]  = a[31:4];
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:4], 4'b0};
    if (la == 32'h8000_0000) return 128'h00100073_00000513_00000413_00000297;
    return {la ^ 32'hdead_beef, ~la, la + 32'h1234_5678, la[15:0], la[31:16]};
  endfunction

  // Observations of the last transaction.
  bit           got_ready;
  logic [127:0] got_data;
  bit           saw_req;
  logic [31:0]  req_addr;
  int           lat;
  int           viol;
  int           beats_sent;

  // Drives one IF request plus the memory side. drop_mode: 1=drop at first beat,
  // 2=drop in MISS_REQ. flush_mode: 1=flush with the request, 2=flush at first beat.
  task automatic read_txn(input logic [31:0] addr, input int drop_mode, input int flush_mode,
                          input int gnt_dly, input int gap);
    int cnt, mphase, beat, done_cyc;
    bit dropped;
    logic [127:0] line;
    line = mem_line(addr);
    got_ready = 0; got_data = '0; saw_req = 0; req_addr = '0; lat = -1; viol = 0;
    mphase = 0; beat = 0; done_cyc = 0; dropped = 0; cnt = 0;
    @(negedge clk);
    valid_i = 1'b1; addr_i = addr;
    if (flush_mode == 1) flush_i = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
      if (ready_o) begin
        got_ready = 1; got_data = r_data_o; lat = cyc; valid_i = 1'b0;
        break;
      end
      if (mphase == 0 && mem_req_o) begin
        saw_req = 1; req_addr = mem_addr_o; cnt = gnt_dly; mphase = 1;
        if (drop_mode == 2) begin valid_i = 1'b0; dropped = 1; end
      end
      if (mphase == 1) begin
        if (!mem_req_o || mem_addr_o !== req_addr) viol++;
        if (cnt == 0) begin mem_gnt_i = 1'b1; mphase = 2; cnt = gap; end
        else cnt--;
      end else if (mphase == 2) begin
        if (mem_req_o) viol++;
        if (cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = line[beat*64 +: 64];
          mem_rlast_i  = (beat == 1);
          if (beat == 0 && drop_mode == 1) begin valid_i = 1'b0; dropped = 1; end
          if (beat == 0 && flush_mode == 2) flush_i = 1'b1;
          beat++; cnt = gap;
          if (beat == 2) begin mphase = 3; done_cyc = cyc; end
        end else cnt--;
      end else if (mphase == 3 && dropped && cyc >= done_cyc + 3) begin
        break;
      end
    end
    valid_i = 1'b0; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    beats_sent = beat;
  endtask

  task automatic test_reset();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_maddr got=%h exp=0", mem_addr_o); end
    total++; if (r_data_o !== 128'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", r_data_o); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    read_txn(32'h8000_0000, 0, 0, 1, 1);
    model_install(32'h8000_0000);
    total++; if (saw_req !== 1'b1) begin bad++; $display("FAIL cold_req got=%b exp=1", saw_req); end
    total++; if (req_addr !== 32'h8000_0000) begin bad++; $display("FAIL cold_maddr got=%h exp=80000000", req_addr); end
    total++; if (got_ready !== 1'b1) begin bad++; $display("FAIL cold_ready got=%b exp=1", got_ready); end
    total++; if (got_data !== 128'h00100073_00000513_00000413_00000297)
      begin bad++; $display("FAIL cold_data got=%h exp=00100073000005130000041300000297", got_data); end
    total++; if (viol !== 0) begin bad++; $display("FAIL cold_proto got=%0d exp=0", viol); end
  endtask

  task automatic test_hit();
    read_txn(32'h8000_0008, 0, 0, 0, 0);
    total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL hit_req got=%b exp=0", saw_req); end
    total++; if (lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    total++; if (got_data !== mem_line(32'h8000_0000)) begin bad++; $display("FAIL hit_data got=%h exp=%h", got_data, mem_line(32'h8000_0000)); end
  endtask

  task automatic test_conflict();
    read_txn(32'h8000_0400, 0, 0, 2, 0);
    model_install(32'h8000_0400);
    total++; if (req_addr !== 32'h8000_0400) begin bad++; $display("FAIL conf_maddr got=%h exp=80000400", req_addr); end
    total++; if (got_data !== mem_line(32'h8000_0400)) begin bad++; $display("FAIL conf_data got=%h exp=%h", got_data, mem_line(32'h8000_0400)); end
    read_txn(32'h8000_0004, 0, 0, 0, 2);
    model_install(32'h8000_0000);
    total++; if (saw_req !== 1'b1) begin bad++; $display("FAIL conf_evicted got=%b exp=1", saw_req); end
    total++; if (got_data !== mem_line(32'h8000_0000)) begin bad++; $display("FAIL conf_data2 got=%h exp=%h", got_data, mem_line(32'h8000_0000)); end
  endtask

  task automatic test_flush();
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    model_flush();
    read_txn(32'h8000_0000, 0, 0, 0, 0);
    model_install(32'h8000_0000);
    total++; if (saw_req !== 1'b1) begin bad++; $display("FAIL flush_idle_req got=%b exp=1", saw_req); end
    read_txn(32'h8000_0010, 0, 2, 1, 1);
    total++; if (got_ready !== 1'b1) begin bad++; $display("FAIL flush_refill_ready got=%b exp=1", got_ready); end
    total++; if (got_data !== mem_line(32'h8000_0010)) begin bad++; $display("FAIL flush_refill_data got=%h exp=%h", got_data, mem_line(32'h8000_0010)); end
    model_flush();
    read_txn(32'h8000_0010, 0, 0, 0, 0);
    model_install(32'h8000_0010);
    total++; if (saw_req !== 1'b1) begin bad++; $display("FAIL flush_refill_again got=%b exp=1", saw_req); end
    read_txn(32'h8000_0010, 0, 1, 0, 0);
    model_flush(); model_install(32'h8000_0010);
    total++; if (saw_req !== 1'b1) begin bad++; $display("FAIL flush_with_valid got=%b exp=1", saw_req); end
  endtask

  task automatic test_drop();
    read_txn(32'h8000_0020, 1, 0, 1, 1);
    model_install(32'h8000_0020);
    total++; if (got_ready !== 1'b0) begin bad++; $display("FAIL drop_ready got=%b exp=0", got_ready); end
    total++; if (beats_sent !== 2) begin bad++; $display("FAIL drop_beats got=%0d exp=2", beats_sent); end
    read_txn(32'h8000_002c, 0, 0, 0, 0);
    total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL drop_rehit_req got=%b exp=0", saw_req); end
    total++; if (lat !== 2) begin bad++; $display("FAIL drop_rehit_lat got=%0d exp=2", lat); end
    total++; if (got_data !== mem_line(32'h8000_0020)) begin bad++; $display("FAIL drop_rehit_data got=%h exp=%h", got_data, mem_line(32'h8000_0020)); end
    read_txn(32'h8000_0830, 2, 0, 2, 0);
    model_install(32'h8000_0830);
    total++; if (got_ready !== 1'b0) begin bad++; $display("FAIL drop_missreq_ready got=%b exp=0", got_ready); end
  endtask

  task automatic test_reset_mid_refill();
    bit seen;
    seen = 0;
    @(negedge clk); valid_i = 1'b1; addr_i = 32'h8000_0030;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req_o;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b exp=1", seen); end
    mem_gnt_i = 1'b1;
    @(negedge clk); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444; mem_rlast_i = 1'b0;
    @(negedge clk); mem_rvalid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rstmid_maddr got=%h exp=0", mem_addr_o); end
    total++; if (r_data_o !== 128'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", r_data_o); end
    total++; if (ready_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b%b exp=00", ready_o, mem_req_o); end
    valid_i = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    model_flush();
    read_txn(32'h8000_0030, 0, 0, 0, 0);
    model_install(32'h8000_0030);
    total++; if (saw_req !== 1'b1 || got_data !== mem_line(32'h8000_0030))
      begin bad++; $display("FAIL rstmid_after got=%b/%h exp=1/%h", saw_req, got_data, mem_line(32'h8000_0030)); end
    read_txn(32'h8000_0010, 0, 0, 0, 0);
    model_install(32'h8000_0010);
    total++; if (saw_req !== 1'b1) begin bad++; $display("FAIL rstmid_lost_line got=%b exp=1", saw_req); end
  endtask

  task automatic test_random();
    int idxs [4] = '{0, 1, 5, 63};
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int dm, fm;
      bit exp_hit, exp_ready;
      a = 32'h8000_0000 + 32'(idxs[$urandom_range(3, 0)] * 16) + 32'($urandom_range(2, 0) * 32'h400)
          + 32'($urandom_range(15, 0));
      dm = ($urandom_range(7, 0) == 0) ? 1 : 0;
      fm = ($urandom_range(9, 0) == 0) ? 1 : (($urandom_range(9, 0) == 0) ? 2 : 0);
      if (fm == 1) model_flush();
      exp_hit   = model_hit(a);
      exp_ready = exp_hit || dm == 0;
      read_txn(a, dm, fm, $urandom_range(3, 0), $urandom_range(2, 0));
      if (!exp_hit) model_install(a);
      if (fm == 2 && !exp_hit) model_flush();
      total++; if (saw_req !== !exp_hit) begin bad++; $display("FAIL rnd_req a=%h got=%b exp=%b", a, saw_req, !exp_hit); end
      total++; if (got_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready a=%h got=%b exp=%b", a, got_ready, exp_ready); end
      if (exp_ready) begin
        total++; if (got_data !== mem_line(a)) begin bad++; $display("FAIL rnd_data a=%h got=%h exp=%h", a, got_data, mem_line(a)); end
      end
      if (exp_hit && fm == 0) begin
        total++; if (lat !== 2) begin bad++; $display("FAIL rnd_lat a=%h got=%0d exp=2", a, lat); end
      end
      total++; if (viol !== 0) begin bad++; $display("FAIL rnd_proto a=%h got=%0d exp=0", a, viol); end
    end
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; addr_i = '0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rlast_i = 1'b0;
    model_flush();
    for (int i = 0; i < 64; i++) mline[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_drop();
    test_reset_mid_refill();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
